// File: rtl/port_uart_pkg.sv
// -----------------------------------------------------------------------------
// port_uart_pkg
// Shared types and constants for the port-attached UART transmitter.
//   uart_state_t : transmit FSM states (IDLE, START, DATA, STOP)
//   STS_*        : bit positions inside the CPU-visible status byte
//   BYTE_W       : width of one transmitted character
//   DATA_BITS    : data bits per 8N1 frame
// -----------------------------------------------------------------------------
package port_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // Status byte layout: {5'b0, overflow, busy, full}
    localparam int STS_FULL = 0;
    localparam int STS_BUSY = 1;
    localparam int STS_OVF  = 2;

    localparam int BYTE_W    = 8;
    localparam int DATA_BITS = 8;

endpackage

// File: rtl/byte_fifo.sv
// -----------------------------------------------------------------------------
// byte_fifo
// Small synchronous byte FIFO, first-word-not-fall-through: o_data is loaded
// by a pop and holds that byte until the next pop.
//   i_clk    : clock
//   i_reset  : synchronous active-high reset (flushes the FIFO)
//   i_push   : write request, ignored while o_full is set
//   i_data   : byte written on an accepted push
//   i_pop    : read request, ignored while o_empty is set
//   o_data   : byte delivered by the most recent accepted pop
//   o_count  : registered occupancy, 0..DEPTH
//   o_full   : registered, o_count == DEPTH
//   o_empty  : registered, o_count == 0
// -----------------------------------------------------------------------------
module byte_fifo
    import port_uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_push,
    input  logic [BYTE_W-1:0]        i_data,
    input  logic                     i_pop,
    output logic [BYTE_W-1:0]        o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [BYTE_W-1:0] r_mem [DEPTH];
    logic [BYTE_W-1:0] r_data;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_full;
    logic              r_empty;

    logic              w_push_ok;
    logic              w_pop_ok;
    logic [CNT_W-1:0]  w_count_nxt;

    // Gating uses the registered flags, so a push while full is dropped even
    // when a pop frees a slot in the same cycle.
    assign w_push_ok = i_push && !r_full;
    assign w_pop_ok  = i_pop && !r_empty;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push_ok && !w_pop_ok) begin
            w_count_nxt = r_count + CNT_W'(1);
        end else if (w_pop_ok && !w_push_ok) begin
            w_count_nxt = r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CNT_W'(DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

    // Storage and read register carry data only; they need no reset.
    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
        if (w_pop_ok) begin
            r_data <= r_mem[r_rd_ptr];
        end
    end

    assign o_data  = r_data;
    assign o_count = r_count;
    assign o_full  = r_full;
    assign o_empty = r_empty;

endmodule

// File: rtl/port_uart_tx.sv
// -----------------------------------------------------------------------------
// port_uart_tx
// 8N1 UART transmitter hanging off a CPU output port. Bytes written through
// the port are queued in a byte FIFO and shifted out LSB first; a status
// byte is returned to a CPU input port so software can poll before writing.
//   clk     : system clock
//   reset   : synchronous active-high reset (flushes FIFO, abandons frame)
//   wr_en   : one-cycle write strobe from the output-port decode
//   data_in : byte to queue, sampled when wr_en=1
//   tx      : serial line, idle high, driven from a flop
//   busy    : FIFO non-empty or frame in progress (registered)
//   full    : FIFO holds FIFO_DEPTH bytes (registered)
//   status  : {5'b0, overflow, busy, full}
// -----------------------------------------------------------------------------
module port_uart_tx
    import port_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [BYTE_W-1:0] data_in,
    output logic              tx,
    output logic              busy,
    output logic              full,
    output logic [7:0]        status
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        BIT_LAST  = 3'(DATA_BITS - 1);

    uart_state_t       r_state;
    uart_state_t       w_state_nxt;
    logic [BAUD_W-1:0] r_baud;
    logic [BAUD_W-1:0] w_baud_nxt;
    logic [2:0]        r_bit;
    logic [2:0]        w_bit_nxt;
    logic [BYTE_W-1:0] r_shift;
    logic [BYTE_W-1:0] w_shift_nxt;
    logic              r_tx;
    logic              w_tx_nxt;
    logic              r_busy;
    logic              w_busy_nxt;
    logic              r_ovf;

    logic              w_pop;
    logic              w_push_ok;
    logic              w_baud_tc;
    logic [BYTE_W-1:0] w_fifo_data;
    logic [CNT_W-1:0]  w_count;
    logic [CNT_W-1:0]  w_count_nxt;
    logic              w_full;
    logic              w_empty;
    logic [7:0]        w_status;

    byte_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_reset (reset),
        .i_push  (wr_en),
        .i_data  (data_in),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_push_ok = wr_en && !w_full;
    assign w_baud_tc = (r_baud == BAUD_LAST);

    // Next-state / datapath decode. The shift register is loaded on leaving
    // START rather than at the pop, because the FIFO output only becomes
    // valid the cycle after the pop and START always lasts >= 2 cycles.
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_pop       = 1'b0;

        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_baud_nxt  = '0;
                    w_state_nxt = START;
                end
            end
            START: begin
                if (w_baud_tc) begin
                    w_baud_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_shift_nxt = w_fifo_data;
                    w_state_nxt = DATA;
                end else begin
                    w_baud_nxt  = r_baud + BAUD_W'(1);
                end
            end
            DATA: begin
                if (w_baud_tc) begin
                    w_baud_nxt  = '0;
                    w_shift_nxt = {1'b0, r_shift[BYTE_W-1:1]};
                    if (r_bit == BIT_LAST) begin
                        w_state_nxt = STOP;
                    end else begin
                        w_bit_nxt   = r_bit + 3'd1;
                    end
                end else begin
                    w_baud_nxt  = r_baud + BAUD_W'(1);
                end
            end
            STOP: begin
                if (w_baud_tc) begin
                    w_baud_nxt = '0;
                    // Chain straight into the next start bit when data waits.
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = START;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_baud_nxt = r_baud + BAUD_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // tx is registered from the next state so the start bit appears on
        // the cycle the FSM enters START.
        case (w_state_nxt)
            START:   w_tx_nxt = 1'b0;
            DATA:    w_tx_nxt = w_shift_nxt[0];
            default: w_tx_nxt = 1'b1;
        endcase
    end

    // FIFO occupancy one cycle ahead, so busy lines up with the count.
    always_comb begin
        w_count_nxt = w_count;
        if (w_push_ok && !w_pop) begin
            w_count_nxt = w_count + CNT_W'(1);
        end else if (w_pop && !w_push_ok) begin
            w_count_nxt = w_count - CNT_W'(1);
        end
        w_busy_nxt = (w_state_nxt != IDLE) || (w_count_nxt != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_tx    <= w_tx_nxt;
            r_busy  <= w_busy_nxt;
            // Sticky until reset: a write arrived while the FIFO was full.
            if (wr_en && w_full) begin
                r_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        r_shift <= w_shift_nxt;
    end

    always_comb begin
        w_status           = '0;
        w_status[STS_FULL] = w_full;
        w_status[STS_BUSY] = r_busy;
        w_status[STS_OVF]  = r_ovf;
    end

    assign tx     = r_tx;
    assign busy   = r_busy;
    assign full   = w_full;
    assign status = w_status;

endmodule

// File: tb/tb_port_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_port_uart_tx
// Directed bench for port_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4. Written
// bytes that should be transmitted go into a scoreboard queue; a serial
// monitor decodes frames off tx and compares them with the queue head.
// -----------------------------------------------------------------------------
module tb_port_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic       wr_en   = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       tx;
    logic       busy;
    logic       full;
    logic [7:0] status;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    int         starts[$];

    port_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .data_in (data_in),
        .tx      (tx),
        .busy    (busy),
        .full    (full),
        .status  (status)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] b, input bit expect_tx);
        wr_en   = 1'b1;
        data_in = b;
        if (expect_tx) exp_q.push_back(b);
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
    endtask

    // Serial monitor: samples mid-bit on the falling edge.
    initial begin : monitor
        int         s;
        bit         ab;
        logic [7:0] b;
        logic       sb;
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && tx === 1'b0) begin
                s  = cyc;
                ab = 1'b0;
                b  = '0;
                for (int k = 0; k < 8; k++) begin
                    for (int w = 0; w < ((k == 0) ? 6 : 4); w++) begin
                        @(negedge clk);
                        if (reset !== 1'b0) ab = 1'b1;
                    end
                    b[k] = tx;
                end
                for (int w = 0; w < 4; w++) begin
                    @(negedge clk);
                    if (reset !== 1'b0) ab = 1'b1;
                end
                sb = tx;
                if (!ab) begin
                    starts.push_back(s);
                    check("frame_stop_bit", 32'(sb), 32'd1);
                    check("frame_was_queued", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) check("frame_byte", 32'(b), 32'(exp_q.pop_front()));
                end
                @(negedge clk);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int         t0;
        int         base;
        int         d;
        logic [9:0] pat;

        // Reset state
        repeat (3) tick();
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_status", 32'(status), 32'h00);
        reset = 1'b0;
        tick();

        // Idle line after reset
        for (int i = 0; i < 100; i++) begin
            check("idle_line", 32'({tx, busy, status}), 32'h200);
            tick();
        end

        // Single byte 8'hA5
        base = starts.size();
        t0   = cyc;
        write_byte(8'hA5, 1'b1);
        check("a5_busy_n1", 32'(busy), 32'd1);
        tick();
        pat = 10'h34A;
        for (int i = 0; i < 40; i++) begin
            check("a5_tx_bit", 32'(tx), 32'(pat[i / 4]));
            check("a5_busy", 32'(busy), 32'd1);
            tick();
        end
        check("a5_busy_fall", 32'(busy), 32'd0);
        tick();
        check("a5_frames", 32'(starts.size() - base), 32'd1);
        if (starts.size() > base) check("a5_start_cycle", 32'(starts[base] - t0), 32'd2);

        // Six back-to-back writes, sixth dropped
        base = starts.size();
        t0   = cyc;
        for (int i = 1; i <= 6; i++) write_byte(8'(i), i <= 5);
        check("burst_ovf_status", 32'(status), 32'h07);
        wait_idle("burst_done", 400);
        tick();
        check("burst_frames", 32'(starts.size() - base), 32'd5);
        if (starts.size() == base + 5) begin
            check("burst_first_start", 32'(starts[base] - t0), 32'd2);
            for (int k = 1; k < 5; k++)
                check("burst_gap", 32'(starts[base + k] - starts[base + k - 1]), 32'd40);
        end
        check("burst_status_idle", 32'(status), 32'h04);
        check("burst_q_drained", 32'(exp_q.size()), 32'd0);
        pulse_reset();
        check("status_after_reset", 32'(status), 32'h00);
        tick();

        // Write while full in the cycle the FSM pops (STOP -> START)
        base = starts.size();
        t0   = cyc;
        for (int i = 0; i < 5; i++) write_byte(8'(8'hB0 + i), 1'b1);
        check("fill_full", 32'(full), 32'd1);
        while (cyc < t0 + 41) tick();
        check("pre_drop_status", 32'(status), 32'h03);
        write_byte(8'hBF, 1'b0);
        check("drop_full_clear", 32'(full), 32'd0);
        check("drop_status", 32'(status), 32'h06);
        wait_idle("full_pop_done", 400);
        tick();
        check("full_pop_frames", 32'(starts.size() - base), 32'd5);
        if (starts.size() == base + 5) begin
            for (int k = 1; k < 5; k++)
                check("full_pop_gap", 32'(starts[base + k] - starts[base + k - 1]), 32'd40);
        end
        pulse_reset();
        tick();

        // Reset in the middle of DATA with two bytes queued
        base = starts.size();
        t0   = cyc;
        write_byte(8'hC0, 1'b0);
        write_byte(8'hC1, 1'b0);
        write_byte(8'hC2, 1'b0);
        while (cyc < t0 + 20) tick();
        check("mid_in_frame", 32'(busy), 32'd1);
        pulse_reset();
        check("mid_rst_tx", 32'(tx), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_full", 32'(full), 32'd0);
        for (int i = 0; i < 100; i++) begin
            check("post_rst_idle", 32'({tx, busy, status}), 32'h200);
            tick();
        end
        check("post_rst_frames", 32'(starts.size() - base), 32'd0);

        // Write during the final stop-bit cycle of the last queued frame
        base = starts.size();
        t0   = cyc;
        write_byte(8'hD0, 1'b1);
        while (cyc < t0 + 41) tick();
        check("tail_in_stop", 32'({busy, tx}), 32'h3);
        write_byte(8'hD1, 1'b1);
        wait_idle("tail_done", 200);
        tick();
        check("tail_frames", 32'(starts.size() - base), 32'd2);
        if (starts.size() == base + 2) begin
            d = starts[base + 1] - starts[base];
            check("tail_gap_40_or_41", 32'(d == 40 || d == 41), 32'd1);
        end
        check("tail_q_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
